// File: rtl/fp_dsel_ctrl.sv
// Front-panel display-select controller: debounced NEXT/PREV stepping and
// optional auto-scan over six one-hot lamp-mux positions, with a lamp load strobe.
module fp_dsel_ctrl #(
    parameter logic [15:0] DEB_CYCLES  = 16'd50000,
    parameter logic [23:0] SCAN_CYCLES = 24'd5000000,
    parameter int unsigned NPOS        = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw_next,
    input  logic       sw_prev,
    input  logic       scan_en,
    input  logic       freeze,
    output logic [0:5] dsel,
    output logic [0:2] dsel_idx,
    output logic       disp_load,
    output logic       scanning
);

    localparam logic [2:0] LAST = 3'(NPOS - 1);

    typedef enum logic {MANUAL, SCAN} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sync1, sync2, deb, pulse;
    logic [15:0] cnt [2];
    logic [23:0] dwell, dwell_nxt;
    logic        next_p, prev_p, man_inc, man_dec, tick;
    logic        adv_inc, adv_dec, pend;
    logic [2:0]  idx_nxt;

    // Synchronizer and debounce; index 0 = NEXT, index 1 = PREV
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= {sw_prev, sw_next};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_CYCLES - 16'd1) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // Press pulse fires in the cycle the debounced level is about to rise
    always_comb begin
        pulse = '0;
        for (int i = 0; i < 2; i++)
            pulse[i] = sync2[i] & ~deb[i] & (cnt[i] == DEB_CYCLES - 16'd1);
    end

    assign next_p  = pulse[0];
    assign prev_p  = pulse[1];
    assign man_inc = next_p & ~prev_p;
    assign man_dec = prev_p & ~next_p;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= MANUAL;
            scanning <= 1'b0;
            dwell    <= '0;
        end else begin
            state    <= state_nxt;
            scanning <= (state_nxt == SCAN);
            dwell    <= dwell_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MANUAL:  if (scan_en)  state_nxt = SCAN;
            SCAN:    if (!scan_en) state_nxt = MANUAL;
            default: state_nxt = MANUAL;
        endcase
    end

    // Dwell timing and scan tick; a manual pulse in the tick cycle wins
    always_comb begin
        dwell_nxt = dwell;
        tick      = 1'b0;
        case (state)
            SCAN: begin
                if (!scan_en) begin
                    dwell_nxt = '0;
                end else if (!freeze) begin
                    if (man_inc || man_dec) begin
                        dwell_nxt = '0;
                    end else if (dwell == SCAN_CYCLES - 24'd1) begin
                        dwell_nxt = '0;
                        tick      = ~(next_p | prev_p);
                    end else begin
                        dwell_nxt = dwell + 24'd1;
                    end
                end
            end
            default: dwell_nxt = '0;
        endcase
    end

    assign adv_inc = ~freeze & (man_inc | tick);
    assign adv_dec = ~freeze & man_dec;

    always_comb begin
        idx_nxt = dsel_idx;
        if (adv_inc)
            idx_nxt = (dsel_idx == LAST) ? 3'd0 : dsel_idx + 3'd1;
        else if (adv_dec)
            idx_nxt = (dsel_idx == 3'd0) ? LAST : dsel_idx - 3'd1;
    end

    // pend resets high so the initial position is loaded after reset;
    // a strobe that would follow another is deferred by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dsel_idx  <= 3'd0;
            dsel      <= 6'b000001;
            pend      <= 1'b1;
            disp_load <= 1'b0;
        end else begin
            dsel_idx  <= idx_nxt;
            dsel      <= 6'b000001 << idx_nxt;
            pend      <= adv_inc | adv_dec | (pend & disp_load);
            disp_load <= pend & ~disp_load;
        end
    end

endmodule

// File: tb/tb_fp_dsel_ctrl.sv
// Directed testbench for fp_dsel_ctrl with DEB_CYCLES=4, SCAN_CYCLES=10.
module tb_fp_dsel_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sw_next = 1'b0;
    logic       sw_prev = 1'b0;
    logic       scan_en = 1'b0;
    logic       freeze = 1'b0;
    logic [0:5] dsel;
    logic [0:2] dsel_idx;
    logic       disp_load;
    logic       scanning;

    int nchk  = 0;
    int npass = 0;
    int loads;

    logic [5:0] exp_tab [0:5] = '{6'b000001, 6'b000010, 6'b000100,
                                  6'b001000, 6'b010000, 6'b100000};

    fp_dsel_ctrl #(.DEB_CYCLES(16'd4), .SCAN_CYCLES(24'd10)) dut (
        .clk(clk), .reset(reset), .sw_next(sw_next), .sw_prev(sw_prev),
        .scan_en(scan_en), .freeze(freeze), .dsel(dsel), .dsel_idx(dsel_idx),
        .disp_load(disp_load), .scanning(scanning)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; sw_next = 1'b0; sw_prev = 1'b0; scan_en = 1'b0; freeze = 1'b0;
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    task automatic test_reset();
        step(3);
        nchk++; if (dsel !== 6'b000001) $display("FAIL reset_dsel: got %b required 000001", dsel); else npass++;
        nchk++; if (dsel_idx !== 3'd0) $display("FAIL reset_idx: got %0d required 0", dsel_idx); else npass++;
        nchk++; if (disp_load !== 1'b0) $display("FAIL reset_load: got %b required 0", disp_load); else npass++;
        nchk++; if (scanning !== 1'b0) $display("FAIL reset_scanning: got %b required 0", scanning); else npass++;
        reset = 1'b0;
        step(1);
        nchk++; if (disp_load !== 1'b1) $display("FAIL release_load: got %b required 1", disp_load); else npass++;
        step(1);
        nchk++; if (disp_load !== 1'b0) $display("FAIL release_load_off: got %b required 0", disp_load); else npass++;
        loads = 0;
        for (int j = 0; j < 5; j++) begin step(1); loads += int'(disp_load); end
        nchk++; if (loads != 0) $display("FAIL release_quiet: got %0d loads required 0", loads); else npass++;
    endtask

    task automatic test_next6();
        apply_reset();
        for (int k = 1; k <= 6; k++) begin
            sw_next = 1'b1;
            step(5);
            nchk++; if (dsel !== exp_tab[k-1]) $display("FAIL next_early%0d: got %b required %b", k, dsel, exp_tab[k-1]); else npass++;
            step(1);
            nchk++; if (dsel !== exp_tab[k%6]) $display("FAIL next_dsel%0d: got %b required %b", k, dsel, exp_tab[k%6]); else npass++;
            nchk++; if (dsel_idx !== 3'(k%6)) $display("FAIL next_idx%0d: got %0d required %0d", k, dsel_idx, k%6); else npass++;
            nchk++; if (disp_load !== 1'b0) $display("FAIL next_load_same%0d: got %b required 0", k, disp_load); else npass++;
            step(1);
            nchk++; if (disp_load !== 1'b1) $display("FAIL next_load%0d: got %b required 1", k, disp_load); else npass++;
            step(1);
            nchk++; if (disp_load !== 1'b0) $display("FAIL next_load_off%0d: got %b required 0", k, disp_load); else npass++;
            sw_next = 1'b0;
            step(10);
            nchk++; if (dsel !== exp_tab[k%6]) $display("FAIL next_release%0d: got %b required %b", k, dsel, exp_tab[k%6]); else npass++;
        end
    endtask

    task automatic test_prev_wrap();
        apply_reset();
        sw_prev = 1'b1;
        step(6);
        nchk++; if (dsel !== 6'b100000) $display("FAIL prev_wrap_dsel: got %b required 100000", dsel); else npass++;
        nchk++; if (dsel_idx !== 3'd5) $display("FAIL prev_wrap_idx: got %0d required 5", dsel_idx); else npass++;
        sw_prev = 1'b0;
        step(10);
    endtask

    task automatic test_bounce();
        apply_reset();
        loads = 0;
        for (int i = 0; i < 10; i++) begin
            sw_next = (i % 2 == 0);
            for (int j = 0; j < 2; j++) begin step(1); loads += int'(disp_load); end
        end
        nchk++; if (dsel !== exp_tab[0]) $display("FAIL bounce_hold: got %b required %b", dsel, exp_tab[0]); else npass++;
        sw_next = 1'b1;
        for (int j = 0; j < 5; j++) begin step(1); loads += int'(disp_load); end
        nchk++; if (dsel !== exp_tab[0]) $display("FAIL bounce_early: got %b required %b", dsel, exp_tab[0]); else npass++;
        step(1); loads += int'(disp_load);
        nchk++; if (dsel !== exp_tab[1]) $display("FAIL bounce_advance: got %b required %b", dsel, exp_tab[1]); else npass++;
        for (int j = 0; j < 10; j++) begin step(1); loads += int'(disp_load); end
        sw_next = 1'b0;
        for (int j = 0; j < 12; j++) begin step(1); loads += int'(disp_load); end
        nchk++; if (dsel !== exp_tab[1]) $display("FAIL bounce_release: got %b required %b", dsel, exp_tab[1]); else npass++;
        nchk++; if (loads != 1) $display("FAIL bounce_loads: got %0d required 1", loads); else npass++;
    endtask

    task automatic test_scan_freeze();
        apply_reset();
        scan_en = 1'b1;
        step(1);
        nchk++; if (scanning !== 1'b1) $display("FAIL scan_enter: got %b required 1", scanning); else npass++;
        for (int a = 1; a <= 6; a++) begin
            step(9);
            nchk++; if (dsel !== exp_tab[(a-1)%6]) $display("FAIL scan_dwell%0d: got %b required %b", a, dsel, exp_tab[(a-1)%6]); else npass++;
            step(1);
            nchk++; if (dsel !== exp_tab[a%6]) $display("FAIL scan_tick%0d: got %b required %b", a, dsel, exp_tab[a%6]); else npass++;
        end
        step(3);
        freeze = 1'b1;
        sw_next = 1'b1;
        loads = 0;
        for (int j = 0; j < 25; j++) begin
            if (j == 10) sw_next = 1'b0;
            step(1);
            loads += int'(disp_load);
        end
        nchk++; if (dsel !== exp_tab[0]) $display("FAIL freeze_hold: got %b required %b", dsel, exp_tab[0]); else npass++;
        nchk++; if (loads != 0) $display("FAIL freeze_loads: got %0d required 0", loads); else npass++;
        freeze = 1'b0;
        step(6);
        nchk++; if (dsel !== exp_tab[0]) $display("FAIL freeze_resume_wait: got %b required %b", dsel, exp_tab[0]); else npass++;
        step(1);
        nchk++; if (dsel !== exp_tab[1]) $display("FAIL freeze_resume_tick: got %b required %b", dsel, exp_tab[1]); else npass++;
        scan_en = 1'b0;
        step(1);
        nchk++; if (scanning !== 1'b0) $display("FAIL scan_exit: got %b required 0", scanning); else npass++;
        step(12);
        nchk++; if (dsel !== exp_tab[1]) $display("FAIL scan_exit_retain: got %b required %b", dsel, exp_tab[1]); else npass++;
    endtask

    task automatic test_both();
        apply_reset();
        sw_next = 1'b1;
        sw_prev = 1'b1;
        loads = 0;
        for (int j = 0; j < 10; j++) begin step(1); loads += int'(disp_load); end
        nchk++; if (dsel !== exp_tab[0]) $display("FAIL both_dsel: got %b required %b", dsel, exp_tab[0]); else npass++;
        nchk++; if (dsel_idx !== 3'd0) $display("FAIL both_idx: got %0d required 0", dsel_idx); else npass++;
        nchk++; if (loads != 0) $display("FAIL both_loads: got %0d required 0", loads); else npass++;
        sw_next = 1'b0;
        sw_prev = 1'b0;
        step(10);
    endtask

    task automatic test_reset_mid_scan();
        apply_reset();
        scan_en = 1'b1;
        step(15);
        nchk++; if (dsel !== exp_tab[1]) $display("FAIL midscan_pos: got %b required %b", dsel, exp_tab[1]); else npass++;
        reset = 1'b1;
        #1;
        nchk++; if (dsel !== 6'b000001) $display("FAIL midscan_reset_dsel: got %b required 000001", dsel); else npass++;
        nchk++; if (dsel_idx !== 3'd0) $display("FAIL midscan_reset_idx: got %0d required 0", dsel_idx); else npass++;
        nchk++; if (scanning !== 1'b0) $display("FAIL midscan_reset_scanning: got %b required 0", scanning); else npass++;
        nchk++; if (disp_load !== 1'b0) $display("FAIL midscan_reset_load: got %b required 0", disp_load); else npass++;
        scan_en = 1'b0;
        step(2);
        reset = 1'b0;
        step(2);
    endtask

    initial begin
        test_reset();
        test_next6();
        test_prev_wrap();
        test_bounce();
        test_scan_freeze();
        test_both();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/fp_dsel_ctrl.md
Name: fp_dsel_ctrl

Overview:
Front-panel display-select controller for the PDP-8/E front panel. It debounces the operator's NEXT/PREV select switches and optionally auto-scans the display. It drives the 6-bit one-hot `dsel` bus that steers the display data mux onto the front-panel lamps. It also issues a one-cycle `disp_load` strobe so the lamp register captures the mux output after it has settled.

Parameters:
- DEB_CYCLES, 16'd50000, number of clocks a synchronized switch level must stay stable before it is accepted.
- SCAN_CYCLES, 24'd5000000, dwell time in clocks per position in auto-scan mode.
- NPOS, 6, number of display positions (fixed; the `dsel` width).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- sw_next  input  1  raw NEXT switch, active-high, asynchronous to clk
- sw_prev  input  1  raw PREV switch, active-high, asynchronous to clk
- scan_en  input  1  level: 1 = auto-scan mode
- freeze  input  1  level: 1 = hold current position; ignore all advances
- dsel  output  [0:5]  one-hot display select to the data mux
- dsel_idx  output  [0:2]  binary position index, 0..5
- disp_load  output  1  one-cycle lamp-register load strobe
- scanning  output  1  1 while the FSM is in SCAN

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - dsel=6'b000001, dsel_idx=0, disp_load=0, scanning=0.
  - FSM=MANUAL; debounce and dwell counters cleared.
  - Debounced switch states = 0.
  - Reset asserted mid-scan or mid-debounce aborts the operation with no strobe.
- Position encoding: position k asserts dsel[5-k]. k=0 gives 000001; k=5 gives 100000. `dsel` is always exactly one-hot, never all-zero.
- Switch input path, per switch:
  - 2-FF synchronizer, then a debounce counter.
  - The counter restarts on any change of the synchronized level.
  - When the level has been stable for DEB_CYCLES, the debounced state updates.
  - A 0→1 debounced transition produces a one-cycle pulse: next_p or prev_p.
  - Release produces no pulse. Holding the switch produces exactly one pulse (no auto-repeat).
  - Minimum latency from raw edge to pulse: 2 + DEB_CYCLES clocks.
- Advance rules, evaluated each cycle with freeze=0:
  - next_p alone: k ← (k+1) mod 6. 5 wraps to 0.
  - prev_p alone: k ← (k+5) mod 6. 0 wraps to 5.
  - next_p and prev_p in the same cycle: no change, no strobe.
  - Scan tick coinciding with a manual pulse: the manual pulse wins; the tick is discarded.
- freeze=1: the position holds and pulses and ticks are dropped, not queued. The dwell counter holds its value.
- FSM:
  - MANUAL: scanning=0, dwell counter at 0. Go to SCAN when scan_en=1.
  - SCAN: scanning=1. The dwell counter increments each unfrozen cycle. On reaching SCAN_CYCLES-1 it issues a tick (advance +1) and clears.
  - Any manual advance in SCAN clears the dwell counter, so a full dwell follows.
  - SCAN returns to MANUAL when scan_en=0. The counter clears and the position is retained.
- disp_load:
  - Pulses for one cycle, exactly 1 clock after any cycle in which `dsel` changed.
  - Also pulses once 1 clock after reset deasserts, to load the initial position.
  - Never asserted for two consecutive cycles.
- dsel and dsel_idx are registered and update on the same edge.

Test Plan:
- Sim parameters DEB_CYCLES=4, SCAN_CYCLES=10.
- Reset release → dsel=000001, dsel_idx=0, disp_load high for exactly one cycle, 1 clk after release, then low.
- sw_next pulsed clean, 6 times with gaps → dsel sequence 000010, 000100, 001000, 010000, 100000, 000001. Each change is followed 1 clk later by one disp_load.
- From reset, one clean sw_prev press → dsel=100000, dsel_idx=5 (wrap-down).
- Bounce: sw_next toggled 0/1 every 2 clks for 20 clks, then held 1 → exactly one advance, occurring 2+4 clks after the final edge. Release → no change.
- scan_en=1 from position 0 → advance every 10 clks, wrapping 5→0. Assert freeze for 25 clks → no advance during freeze. Deassert → the remaining dwell completes before the next advance.
- Next and prev debounced pulses in the same cycle → position unchanged, no disp_load. Assert reset mid-scan → immediate dsel=000001 and scanning=0.
